// File: rtl/router_port_endpoint_pkg.sv
// Shared types and constants for the router-side node link endpoint.
// pkt_t      : 4-byte packet {src, dest, data}; byte 0 on the wire is {src, dest}.
// PKT_BYTES  : bytes per packet, fixed by the width of pkt_t.
// rx/tx enums: state encodings for the inbound and outbound FSMs.
// pkt_byte() : selects wire byte k of a packet, MSB first.
package router_port_endpoint_pkg;

  localparam int PKT_BYTES = 4;
  localparam int IDX_W     = $clog2(PKT_BYTES);

  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dest;
    logic [23:0] data;
  } pkt_t;

  typedef enum logic {
    RX_IDLE,
    RX_RECV
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_WAIT,
    TX_SEND
  } tx_state_e;

  function automatic logic [7:0] pkt_byte(input pkt_t p, input logic [IDX_W-1:0] idx);
    logic [8*PKT_BYTES-1:0] bits;
    bits = p;
    return bits[8*(PKT_BYTES-1-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/router_port_endpoint_if.sv
// Bundle of every non-clock signal of one router port endpoint.
// Node side : free_to_node/put_from_node/payload_from_node (inbound),
//             node_free/put_to_node/payload_to_node (outbound).
// Core side : rx_pkt/rx_valid/rx_ready/rx_err (inbound),
//             tx_pkt/tx_valid/tx_ready (outbound).
// slave  modport: the endpoint itself.
// master modport: the surrounding node + router core.
interface router_port_endpoint_if;
  import router_port_endpoint_pkg::*;

  logic       free_to_node;
  logic       put_from_node;
  logic [7:0] payload_from_node;
  pkt_t       rx_pkt;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_err;
  pkt_t       tx_pkt;
  logic       tx_valid;
  logic       tx_ready;
  logic       node_free;
  logic       put_to_node;
  logic [7:0] payload_to_node;

  modport slave (
    output free_to_node, rx_pkt, rx_valid, rx_err, tx_ready, put_to_node, payload_to_node,
    input  put_from_node, payload_from_node, rx_ready, tx_pkt, tx_valid, node_free
  );

  modport master (
    input  free_to_node, rx_pkt, rx_valid, rx_err, tx_ready, put_to_node, payload_to_node,
    output put_from_node, payload_from_node, rx_ready, tx_pkt, tx_valid, node_free
  );

endinterface

// File: rtl/router_port_endpoint_pkt_queue.sv
// pkt_queue: small circular FIFO with a combinational head.
// clock/reset : rising-edge clock, asynchronous active-high reset (empties the queue)
// wr_en/wr_data : push on the clock edge (ignored when full)
// rd_en/rd_data : rd_data is the current head; rd_en removes it (ignored when empty)
// full/empty/count : occupancy status from registers
module pkt_queue #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 32,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = wr_en && !full;
  assign do_pop  = rd_en && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/router_port_endpoint.sv
// router_port_endpoint: router-side end of the byte-serial node link.
// Inbound : assembles 4-byte packets put by the node (MSB first) and buffers
//           them in an RX_DEPTH-deep queue presented to the router core.
// Outbound: takes one packet from the router core, waits for node_free, then
//           streams its 4 bytes back-to-back to the node.
// Ports: clock, reset (async, active-high), port (router_port_endpoint_if.slave).
module router_port_endpoint
  import router_port_endpoint_pkg::*;
#(
  parameter int RX_DEPTH = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  router_port_endpoint_if.slave       port
);

  localparam int CNT_W = $clog2(RX_DEPTH + 1);

  rx_state_e                  rx_state_q, rx_state_d;
  logic [IDX_W-1:0]           rx_idx_q, rx_idx_d;
  logic [8*(PKT_BYTES-1)-1:0] rx_shift_q, rx_shift_d;
  logic                       rx_err_q, rx_err_d;
  logic [8*PKT_BYTES-1:0]     rx_asm;
  logic [8*PKT_BYTES-1:0]     rx_head;
  logic                       rx_push, rx_full, rx_empty, free;
  logic [CNT_W-1:0]           rx_count;

  tx_state_e                  tx_state_q, tx_state_d;
  logic [IDX_W-1:0]           tx_idx_q, tx_idx_d;
  pkt_t                       tx_pkt_q, tx_pkt_d;
  logic                       put_out;
  logic [7:0]                 payload_out;

  pkt_queue #(
    .DEPTH (RX_DEPTH),
    .WIDTH ($bits(pkt_t))
  ) rx_queue (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (rx_push),
    .wr_data (rx_asm),
    .rd_en   (port.rx_ready),
    .rd_data (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

  // Free only between packets and only while a whole packet still fits.
  assign free              = (rx_state_q == RX_IDLE) && (rx_count < CNT_W'(RX_DEPTH));
  assign rx_asm            = {rx_shift_q, port.payload_from_node};
  assign port.free_to_node = free;
  assign port.rx_pkt       = pkt_t'(rx_head);
  assign port.rx_valid     = !rx_empty;
  assign port.rx_err       = rx_err_q;

  // Inbound FSM: shifts bytes in; the last byte is pushed straight from
  // the bus so the packet lands in the queue on the edge it arrives.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_err_d   = 1'b0;
    rx_push    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (port.put_from_node && free) begin
          rx_shift_d = rx_asm[8*(PKT_BYTES-1)-1:0];
          rx_idx_d   = IDX_W'(1);
          rx_state_d = RX_RECV;
        end
      end
      RX_RECV: begin
        if (port.put_from_node) begin
          rx_shift_d = rx_asm[8*(PKT_BYTES-1)-1:0];
          if (rx_idx_q == IDX_W'(PKT_BYTES - 1)) begin
            rx_push    = !rx_full;
            rx_idx_d   = '0;
            rx_state_d = RX_IDLE;
          end else begin
            rx_idx_d = rx_idx_q + IDX_W'(1);
          end
        end else begin
          rx_idx_d   = '0;
          rx_err_d   = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Outbound FSM: byte 0 goes out combinationally as soon as node_free is
  // seen in WAIT; after that the rest is committed and ignores node_free.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_idx_d    = tx_idx_q;
    tx_pkt_d    = tx_pkt_q;
    put_out     = 1'b0;
    payload_out = 8'h00;
    case (tx_state_q)
      TX_IDLE: begin
        if (port.tx_valid) begin
          tx_pkt_d   = port.tx_pkt;
          tx_state_d = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (port.node_free) begin
          put_out     = 1'b1;
          payload_out = pkt_byte(tx_pkt_q, '0);
          tx_idx_d    = IDX_W'(1);
          tx_state_d  = TX_SEND;
        end
      end
      TX_SEND: begin
        put_out     = 1'b1;
        payload_out = pkt_byte(tx_pkt_q, tx_idx_q);
        if (tx_idx_q == IDX_W'(PKT_BYTES - 1)) begin
          tx_idx_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_idx_d = tx_idx_q + IDX_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign port.tx_ready        = (tx_state_q == TX_IDLE);
  assign port.put_to_node     = put_out;
  assign port.payload_to_node = payload_out;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_err_q   <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_idx_q   <= '0;
      tx_pkt_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_err_q   <= rx_err_d;
      tx_state_q <= tx_state_d;
      tx_idx_q   <= tx_idx_d;
      tx_pkt_q   <= tx_pkt_d;
    end
  end

endmodule

// File: tb/tb_router_port_endpoint.sv
// Directed self-checking bench for router_port_endpoint (RX_DEPTH = 2).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge of the same cycle.
module tb_router_port_endpoint;
  import router_port_endpoint_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   tb_compared   = 0;
  int   tb_mismatched = 0;

  router_port_endpoint_if bus();

  router_port_endpoint #(.RX_DEPTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .port  (bus)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // Watchdog so the run always ends even if the flow stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, compared %0d", tb_compared);
    $fatal(1, "[TB] watchdog expired");
  end

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tb_compared++;
    if (got !== exp) begin
      tb_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive every endpoint input at once.
  task automatic applyStimulus(input logic put, input logic [7:0] data, input logic rdy,
                               input logic txv, input logic [31:0] txp, input logic nfree);
    bus.put_from_node     = put;
    bus.payload_from_node = data;
    bus.rx_ready          = rdy;
    bus.tx_valid          = txv;
    bus.tx_pkt            = pkt_t'(txp);
    bus.node_free         = nfree;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  // Node puts a full packet on consecutive cycles, then idles the bus.
  task automatic sendRxPacket(input logic [31:0] p);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, p[31-8*i -: 8], 1'b0, 1'b0, 32'h0, 1'b0);
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [7:0]  rx1_bytes [4];
    logic [7:0]  tx1_bytes [4];
    logic [7:0]  tx2_bytes [4];
    logic [7:0]  tx3_bytes [4];
    rx1_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
    tx1_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    tx2_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    tx3_bytes = '{8'h24, 8'h68, 8'hAC, 8'hE0};

    // ---- reset state ----
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    checkOutput("rst_put_to_node", bus.put_to_node, 0);
    checkOutput("rst_payload", bus.payload_to_node, 0);
    checkOutput("rst_rx_valid", bus.rx_valid, 0);
    checkOutput("rst_rx_err", bus.rx_err, 0);
    checkOutput("rst_tx_ready", bus.tx_ready, 1);
    checkOutput("rst_free", bus.free_to_node, 1);
    step();
    step();
    reset = 1'b0;

    // ---- single inbound packet ----
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, rx1_bytes[i], 1'b0, 1'b0, 32'h0, 1'b0);
      settle();
      checkOutput("rx1_free", bus.free_to_node, (i == 0) ? 32'd1 : 32'd0);
      checkOutput("rx1_valid_early", bus.rx_valid, 0);
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);
    settle();
    checkOutput("rx1_valid", bus.rx_valid, 1);
    checkOutput("rx1_pkt", bus.rx_pkt, 32'h12345678);
    checkOutput("rx1_free_after", bus.free_to_node, 1);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    checkOutput("rx1_popped", bus.rx_valid, 0);
    step();

    // ---- buffer fills to depth 2, third packet waits ----
    sendRxPacket(32'h11223344);
    settle();
    checkOutput("fill_a_free", bus.free_to_node, 1);
    step();
    sendRxPacket(32'h55667788);
    settle();
    checkOutput("fill_full_free", bus.free_to_node, 0);
    checkOutput("fill_head", bus.rx_pkt, 32'h11223344);
    step();
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    checkOutput("viol_free", bus.free_to_node, 0);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    checkOutput("viol_free_hold", bus.free_to_node, 0);
    step();
    settle();
    checkOutput("viol_no_err", bus.rx_err, 0);
    step();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);
    settle();
    checkOutput("pop_a_head", bus.rx_pkt, 32'h11223344);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    checkOutput("pop_a_free", bus.free_to_node, 1);
    checkOutput("pop_a_next", bus.rx_pkt, 32'h55667788);
    step();
    sendRxPacket(32'h99AABBCC);
    settle();
    checkOutput("third_full", bus.free_to_node, 0);
    step();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);
    settle();
    checkOutput("drain_b", bus.rx_pkt, 32'h55667788);
    step();
    settle();
    checkOutput("drain_c", bus.rx_pkt, 32'h99AABBCC);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    checkOutput("drain_empty", bus.rx_valid, 0);
    step();

    // ---- node drops put mid-packet ----
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    checkOutput("drop_err_early", bus.rx_err, 0);
    checkOutput("drop_free_busy", bus.free_to_node, 0);
    step();
    settle();
    checkOutput("drop_err", bus.rx_err, 1);
    checkOutput("drop_free", bus.free_to_node, 1);
    checkOutput("drop_no_push", bus.rx_valid, 0);
    step();
    settle();
    checkOutput("drop_err_clear", bus.rx_err, 0);
    step();
    sendRxPacket(32'hA5A50001);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);
    settle();
    checkOutput("after_drop_valid", bus.rx_valid, 1);
    checkOutput("after_drop_pkt", bus.rx_pkt, 32'hA5A50001);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
    step();

    // ---- outbound with node_free held low for 3 cycles ----
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    settle();
    checkOutput("tx1_ready_idle", bus.tx_ready, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
      settle();
      checkOutput("tx1_wait_put", bus.put_to_node, 0);
      checkOutput("tx1_wait_payload", bus.payload_to_node, 0);
      checkOutput("tx1_wait_ready", bus.tx_ready, 0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1);
      settle();
      checkOutput("tx1_put", bus.put_to_node, 1);
      checkOutput("tx1_byte", bus.payload_to_node, 32'(tx1_bytes[i]));
      checkOutput("tx1_busy", bus.tx_ready, 0);
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    checkOutput("tx1_ready_back", bus.tx_ready, 1);
    checkOutput("tx1_put_done", bus.put_to_node, 0);
    step();

    // ---- node_free drops after byte 0 ----
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 32'h01020304, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, (i == 0) ? 1'b1 : 1'b0);
      settle();
      checkOutput("tx2_put", bus.put_to_node, 1);
      checkOutput("tx2_byte", bus.payload_to_node, 32'(tx2_bytes[i]));
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    checkOutput("tx2_put_done", bus.put_to_node, 0);
    checkOutput("tx2_ready", bus.tx_ready, 1);
    step();

    // ---- reset mid-RX and mid-TX ----
    sendRxPacket(32'h0F0F0F0F);
    settle();
    checkOutput("pre_rst_valid", bus.rx_valid, 1);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1);
    settle();
    checkOutput("mid_tx_b0", bus.payload_to_node, 32'hCA);
    step();
    applyStimulus(1'b1, 8'hAB, 1'b0, 1'b0, 32'h0, 1'b1);
    settle();
    checkOutput("mid_tx_b1", bus.payload_to_node, 32'hFE);
    step();
    applyStimulus(1'b1, 8'hCD, 1'b0, 1'b0, 32'h0, 1'b1);
    settle();
    checkOutput("mid_tx_b2", bus.payload_to_node, 32'hF0);
    checkOutput("mid_rx_free", bus.free_to_node, 0);
    step();
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1);
    settle();
    checkOutput("mid_rst_put", bus.put_to_node, 0);
    checkOutput("mid_rst_payload", bus.payload_to_node, 0);
    checkOutput("mid_rst_tx_ready", bus.tx_ready, 1);
    checkOutput("mid_rst_free", bus.free_to_node, 1);
    checkOutput("mid_rst_valid", bus.rx_valid, 0);
    checkOutput("mid_rst_err", bus.rx_err, 0);
    step();
    reset = 1'b0;

    // ---- traffic after reset ----
    sendRxPacket(32'h13572468);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);
    settle();
    checkOutput("post_rst_rx_valid", bus.rx_valid, 1);
    checkOutput("post_rst_rx_pkt", bus.rx_pkt, 32'h13572468);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 32'h2468ACE0, 1'b1);
    settle();
    checkOutput("post_rst_rx_empty", bus.rx_valid, 0);
    checkOutput("post_rst_tx_ready", bus.tx_ready, 1);
    step();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1);
      settle();
      checkOutput("post_rst_tx_put", bus.put_to_node, 1);
      checkOutput("post_rst_tx_byte", bus.payload_to_node, 32'(tx3_bytes[i]));
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    checkOutput("post_rst_tx_done", bus.tx_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", tb_compared, tb_mismatched);
    $finish;
  end

endmodule
